// File: rtl/closed_list_search.sv
// Closed-list store and LANES-wide search engine for the A* core.
// Optional macro CLOSED_LIST_SEARCH_STATS_EN adds the search_cycles output.
module closed_list_search #(
  parameter int COORD_W = 8,
  parameter int DEPTH   = 400,
  parameter int LANES   = 4,
  parameter int IDX_W   = $clog2(DEPTH+1)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               clr,
  input  logic               ins_valid,
  input  logic [COORD_W-1:0] ins_x,
  input  logic [COORD_W-1:0] ins_y,
  output logic               ins_ready,
  input  logic               start,
  input  logic [COORD_W-1:0] key_x,
  input  logic [COORD_W-1:0] key_y,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [IDX_W-1:0]   hit_index,
  output logic [IDX_W-1:0]   count,
`ifdef CLOSED_LIST_SEARCH_STATS_EN
  output logic [IDX_W:0]     search_cycles,
`endif
  output logic               full
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W  = 2 * COORD_W;

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [IDX_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic [COORD_W-1:0] key_x_q, key_x_d, key_y_q, key_y_d;
  logic               found_q, found_d;
  logic [IDX_W-1:0]   hit_q, hit_d;
  logic               ins_fire_s;
  logic               lane_hit_s;
  logic [IDX_W-1:0]   lane_idx_s;
  logic [IDX_W:0]     li_s;
  logic               last_grp_s;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign full      = (count_q == IDX_W'(DEPTH));
  assign ins_ready = (state_q == ST_IDLE) && !full;
  assign found     = found_q;
  assign hit_index = hit_q;
  assign count     = count_q;
  // clr wins over a simultaneous insert
  assign ins_fire_s = ins_valid && ins_ready && !clr;

  // Entry storage: deliberately not reset, count alone defines validity
  always_ff @(posedge Clk) begin
    if (ins_fire_s) begin
      mem_q[count_q[ADDR_W-1:0]] <= {ins_x, ins_y};
    end
  end

  // Compare one lane group; scanning high to low leaves the lowest match
  always_comb begin
    lane_hit_s = 1'b0;
    lane_idx_s = '0;
    li_s       = '0;
    for (int l = LANES-1; l >= 0; l--) begin
      li_s = {1'b0, base_q} + (IDX_W+1)'(l);
      if ((li_s < {1'b0, count_q}) && (mem_q[li_s[ADDR_W-1:0]] == {key_x_q, key_y_q})) begin
        lane_hit_s = 1'b1;
        lane_idx_s = li_s[IDX_W-1:0];
      end else begin
        lane_hit_s = lane_hit_s;
      end
    end
    last_grp_s = (({1'b0, base_q} + (IDX_W+1)'(LANES)) >= {1'b0, count_q});
  end

  // Next-state logic for the search FSM and list bookkeeping
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    key_x_d = key_x_q;
    key_y_d = key_y_q;
    found_d = found_q;
    hit_d   = hit_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          count_d = '0;
        end else if (ins_fire_s) begin
          count_d = count_q + IDX_W'(1);
        end else begin
          count_d = count_q;
        end
        if (start) begin
          key_x_d = key_x;
          key_y_d = key_y;
          base_d  = '0;
          found_d = 1'b0;
          hit_d   = '0;
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (lane_hit_s) begin
          found_d = 1'b1;
          hit_d   = lane_idx_s;
          state_d = ST_DONE;
        end else if (last_grp_s) begin
          found_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          base_d  = base_q + IDX_W'(LANES);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      base_q  <= '0;
      key_x_q <= '0;
      key_y_q <= '0;
      found_q <= 1'b0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      key_x_q <= key_x_d;
      key_y_q <= key_y_d;
      found_q <= found_d;
      hit_q   <= hit_d;
    end
  end

`ifdef CLOSED_LIST_SEARCH_STATS_EN
  logic [IDX_W:0] cyc_q;
  assign search_cycles = cyc_q;

  // Counts SEARCH cycles; holds from done until the next accepted start
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cyc_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      cyc_q <= '0;
    end else if (state_q == ST_SEARCH) begin
      cyc_q <= cyc_q + (IDX_W+1)'(1);
    end else begin
      cyc_q <= cyc_q;
    end
  end
`endif

endmodule

// File: tb/tb_closed_list_search.sv
// Directed self-checking bench for closed_list_search (COORD_W=9 so (399,400) fits).
module tb_closed_list_search;
  localparam int CW    = 9;
  localparam int DEPTH = 400;
  localparam int LANES = 4;
  localparam int IW    = $clog2(DEPTH+1);

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          clr = 1'b0;
  logic          ins_valid = 1'b0;
  logic [CW-1:0] ins_x = '0, ins_y = '0;
  logic          ins_ready;
  logic          start = 1'b0;
  logic [CW-1:0] key_x = '0, key_y = '0;
  logic          busy, done, found, full;
  logic [IW-1:0] hit_index, count;
`ifdef CLOSED_LIST_SEARCH_STATS_EN
  logic [IW:0]   search_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  closed_list_search #(.COORD_W(CW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .clr(clr),
    .ins_valid(ins_valid), .ins_x(ins_x), .ins_y(ins_y), .ins_ready(ins_ready),
    .start(start), .key_x(key_x), .key_y(key_y),
    .busy(busy), .done(done), .found(found), .hit_index(hit_index),
    .count(count),
`ifdef CLOSED_LIST_SEARCH_STATS_EN
    .search_cycles(search_cycles),
`endif
    .full(full)
  );

  always #5 Clk = ~Clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ins(input int x, input int y);
    ins_valid = 1'b1;
    ins_x = CW'(x);
    ins_y = CW'(y);
    @(posedge Clk); #1;
    ins_valid = 1'b0;
  endtask

  // start in cycle 0; lat = cycle in which done is seen (-1 on timeout)
  task automatic search(input int kx, input int ky, input bit clr_mid,
                        output int lat, output int bcnt);
    start = 1'b1;
    key_x = CW'(kx);
    key_y = CW'(ky);
    @(posedge Clk); #1;
    start = 1'b0;
    clr   = clr_mid;
    lat   = -1;
    bcnt  = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge Clk);
      bcnt += int'(busy);
      if (done) begin
        lat = c;
        break;
      end
      @(posedge Clk); #1;
    end
    @(posedge Clk); #1;
    clr = 1'b0;
    @(negedge Clk);
    chk_eq("post_done_busy", busy, 0);
    chk_eq("post_done_pulse", done, 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc, seen;
    #12;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_count", count, 0);
    chk_eq("rst_found", found, 0);
    chk_eq("rst_hit", hit_index, 0);
    chk_eq("rst_full", full, 0);
`ifdef CLOSED_LIST_SEARCH_STATS_EN
    chk_eq("rst_stats", search_cycles, 0);
`endif
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk_eq("idle_ready", ins_ready, 1);

    search(0, 0, 1'b0, lat, bc);
    chk_eq("empty_lat", lat, 2);
    chk_eq("empty_found", found, 0);
    chk_eq("empty_hit", hit_index, 0);
    chk_eq("empty_busy_cycles", bc, 2);

    ins(1, 2); ins(3, 4); ins(5, 6);
    chk_eq("three_count", count, 3);
    chk_eq("three_ready", ins_ready, 1);
    search(3, 4, 1'b0, lat, bc);
    chk_eq("s34_lat", lat, 2);
    chk_eq("s34_found", found, 1);
    chk_eq("s34_hit", hit_index, 1);
    search(9, 9, 1'b0, lat, bc);
    chk_eq("s99_lat", lat, 2);
    chk_eq("s99_found", found, 0);
    chk_eq("s99_hit", hit_index, 0);

    clr = 1'b1;
    ins(8, 8);
    clr = 1'b0;
    chk_eq("clr_vs_ins_count", count, 0);

    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 9) ins(7, 7);
      else ins(i + 20, i);
    end
    chk_eq("dup_count", count, 10);
    search(7, 7, 1'b0, lat, bc);
    chk_eq("dup_lat", lat, 2);
    chk_eq("dup_found", found, 1);
    chk_eq("dup_hit", hit_index, 2);
`ifdef CLOSED_LIST_SEARCH_STATS_EN
    chk_eq("dup_stats", search_cycles, 1);
`endif
    search(28, 8, 1'b0, lat, bc);
    chk_eq("grp2_lat", lat, 4);
    chk_eq("grp2_hit", hit_index, 8);
    search(7, 8, 1'b0, lat, bc);
    chk_eq("miss_lat", lat, 4);
    chk_eq("miss_found", found, 0);
`ifdef CLOSED_LIST_SEARCH_STATS_EN
    chk_eq("miss_stats", search_cycles, 3);
`endif
    search(7, 8, 1'b1, lat, bc);
    chk_eq("clr_busy_lat", lat, 4);
    chk_eq("clr_busy_count", count, 10);

    clr = 1'b1;
    @(posedge Clk); #1;
    clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) ins(i, i + 1);
    chk_eq("fill_count", count, 400);
    chk_eq("fill_full", full, 1);
    chk_eq("fill_ready", ins_ready, 0);
    ins(5, 5);
    chk_eq("over_count", count, 400);
    search(399, 400, 1'b0, lat, bc);
    chk_eq("last_lat", lat, 101);
    chk_eq("last_found", found, 1);
    chk_eq("last_hit", hit_index, 399);
`ifdef CLOSED_LIST_SEARCH_STATS_EN
    chk_eq("last_stats", search_cycles, 100);
`endif

    clr = 1'b1;
    @(posedge Clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 200; i++) ins(i, i + 1);
    chk_eq("half_count", count, 200);
    start = 1'b1;
    key_x = CW'(0);
    key_y = CW'(0);
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (10) @(posedge Clk);
    #3;
    chk_eq("mid_busy", busy, 1);
    Reset_n = 1'b0;
    #1;
    chk_eq("arst_busy", busy, 0);
    chk_eq("arst_count", count, 0);
    chk_eq("arst_found", found, 0);
    chk_eq("arst_done", done, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clk);
      seen += int'(done);
    end
    chk_eq("arst_no_done", seen, 0);
    chk_eq("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/closed_list_search.md
Name: closed_list_search

Overview:
- Parametrised closed-list store and search engine for the A* core.
- Holds up to DEPTH visited (x,y) coordinates, written by an insert port.
- On request, scans the list LANES entries per cycle and reports whether a key coordinate is present and at which index.
- Sits beside the open-list queue; the expansion FSM queries it before pushing a neighbour.

Parameters:
- COORD_W, 8, width of each x and y coordinate.
- DEPTH, 400, number of entries in the list.
- LANES, 4, entries compared per cycle; 1..DEPTH; need not divide DEPTH.
- IDX_W, $clog2(DEPTH+1), width of index and count fields.

Ports:
- Clk  input  1  clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- clr  input  1  empty the list (count to 0); honoured only in IDLE.
- ins_valid  input  1  insert request.
- ins_x  input  COORD_W  x coordinate to insert.
- ins_y  input  COORD_W  y coordinate to insert.
- ins_ready  output  1  insert accepted when ins_valid && ins_ready.
- start  input  1  search request; sampled only in IDLE.
- key_x  input  COORD_W  x coordinate to search for; sampled with start.
- key_y  input  COORD_W  y coordinate to search for; sampled with start.
- busy  output  1  high in SEARCH and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- found  output  1  result: key present; held until the next start.
- hit_index  output  IDX_W  lowest matching index; 0 when not found; held until the next start.
- count  output  IDX_W  number of valid entries.
- full  output  1  count == DEPTH.

Behaviour:
- Reset: Reset_n low asynchronously forces the following.
  - FSM goes to IDLE.
  - count=0, found=0, hit_index=0, done=0, busy=0, full=0.
  - Latched key is cleared.
  - Entry storage is not cleared; only count matters.
  - A search in progress is abandoned with no done pulse.
- ins_ready = (state==IDLE) && !full. An accepted insert writes entry[count] and sets count to count+1 at the edge.
- clr in IDLE sets count to 0. clr outweighs a simultaneous insert, which is dropped. clr outside IDLE is ignored.
- FSM states:
  - IDLE: on start, latch key_x/key_y, set base=0, clear found/hit_index, go to SEARCH. An insert accepted in the same cycle as start is included in the search (scan limit = post-insert count).
  - SEARCH: each cycle compare entries base..base+LANES-1; lanes with index >= count are masked.
    - If any lane matches, record the lowest matching index, set found=1, go to DONE.
    - Else, if base+LANES >= count, set found=0, go to DONE.
    - Else, base += LANES and stay in SEARCH.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency: start sampled in cycle 0; a match in lane group g (0-based) gives done high in cycle g+2. Not found gives done in cycle ceil(count/LANES)+1. An empty list gives done in cycle 2 with found=0.
- Inserts are refused (ins_ready=0) in SEARCH and DONE, so the list is stable during a scan.
- start outside IDLE is ignored and is not queued.
- Duplicates are allowed in the store; search returns the lowest index.
- Comparison is exact equality on both x and y, full COORD_W bits.

Optional Feature:
- Macro CLOSED_LIST_SEARCH_STATS_EN.
- Defined: adds output search_cycles (IDX_W+1 bits). It is reset to 0, cleared on an accepted start, incremented each cycle in SEARCH, and holds its value from the done cycle until the next start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, insert (1,2),(3,4),(5,6) with LANES=4 -> count=3, ins_ready=1; search (3,4) -> done in cycle 2, found=1, hit_index=1.
- Empty list, start key (0,0) -> done in cycle 2, found=0, hit_index=0, busy high in cycles 1-2 only.
- Fill 400 entries (i, i+1); search (399,400) -> done in cycle 101, found=1, hit_index=399; full=1 and ins_ready=0, and an insert attempt leaves count=400.
- Insert (7,7) at indices 2 and 9; search (7,7) -> hit_index=2. Search (7,8) -> found=0 after ceil(count/4)+1 cycles. With STATS_EN, search_cycles equals the SEARCH cycle count.
- clr and ins_valid in the same IDLE cycle -> count=0. clr during SEARCH -> ignored, and count is unchanged after done.
- Reset_n pulled low mid-search with 200 entries -> busy=0, count=0, found=0 immediately, and no done pulse follows.
